nrisc_run_monitor: RTL and testbench
====================================

Name: nrisc_run_monitor

Overview:
- Synthesizable run controller and trace monitor for the 8-bit nRisc core and its DataMEM.
- Bounds a program run by a cycle limit and stops on Halt.
- Records a circular trace of retired PC values, with optional register-file snapshots, into an internal buffer that is read back after the run.
- Sits beside the core in bench and FPGA builds, replacing fixed-length clock loops and free-running $monitor dumps with a parametrised, self-stopping, readable trace.

Parameters:
- W, 8, data/PC width in bits.
- NREG, 4, number of watched registers (channels), packed on regs_in.
- DEPTH, 16, trace entries retained; power of two, >= 2.
- AW, 4, address width, = log2(DEPTH).
- MAX_CYCLES, 90, cycle limit per run; >= 1.
- CW, 16, width of cycle_count; must satisfy 2^CW > MAX_CYCLES.

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a run from IDLE or DONE.
- halt_in  in  1  core Halt signal.
- pc_in  in  W  core PC (RF[5]).
- regs_in  in  NREG*W  watched registers; channel k at bits [k*W +: W].
- rd_addr  in  AW  trace read index; 0 = oldest retained entry.
- rd_data  out  W+NREG*W  trace entry read data; {regs,pc} with TRACE_REGS_EN; else PC zero-extended.
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- timeout  out  1  run ended by cycle limit, not halt.
- cycle_count  out  CW  cycles spent in RUN.
- entry_count  out  AW+1  valid entries, saturates at DEPTH.
- overflow  out  1  at least one entry overwritten.

Behaviour:
- Reset (sync, high): state IDLE.
  - running, done, timeout, overflow = 0.
  - cycle_count, entry_count, write pointer, rd_data = 0; last_pc = 0.
  - Reset mid-run aborts immediately; buffer contents are don't-care, entry_count = 0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start.
  - On entry: clear counters and flags, write pointer = 0.
  - last_pc := pc_in; the first cycle never logs.
- RUN, each cycle:
  - cycle_count += 1.
  - If pc_in != last_pc: write entry at write pointer, pointer wraps mod DEPTH, last_pc := pc_in.
  - entry_count += 1, saturating at DEPTH.
  - A write while entry_count == DEPTH sets overflow (sticky until next start).
- RUN -> DONE, evaluated with priority halt over limit:
  - halt_in = 1: done = 1, timeout = 0. The same-cycle PC-change write still occurs.
  - Else if cycle_count == MAX_CYCLES-1 (this cycle being the last): done = 1, timeout = 1.
  - The cycle-count increment in that cycle still occurs, so cycle_count = MAX_CYCLES on timeout.
- DONE holds all outputs; start re-enters RUN (same as from IDLE). start during RUN is ignored.
- Read port:
  - rd_data registered, 1-cycle latency; valid in any state.
  - Physical index = (wr_ptr - entry_count + rd_addr) mod DEPTH.
  - rd_addr >= entry_count returns 0.
- Simultaneous events:
  - halt_in on the first RUN cycle: DONE next edge, cycle_count = 1.
  - start and Reset together: Reset wins.

Optional Feature:
- Macro: NRISC_TRACE_REGS_EN.
- Defined: each entry stores {regs_in, pc_in}; rd_data = full W+NREG*W entry.
- Undefined: only pc_in is stored (buffer W bits wide); rd_data upper NREG*W bits = 0; regs_in ignored.
- Control behaviour is identical in both builds.

Test Plan:
- Reset mid-run:
  - Stimulus: start; pc_in steps 0,1,2; assert Reset at cycle 3.
  - Response: next edge state IDLE, entry_count = 0, running = 0, done = 0.
- Halt stop (macro defined):
  - Stimulus: start; pc_in = 0,1,2,3; halt_in at cycle 5.
  - Response: done = 1, timeout = 0, entry_count = 3, rd_addr 0..2 -> pc 1,2,3 with matching regs_in snapshots.
- Timeout:
  - Stimulus: MAX_CYCLES = 90, pc_in constant 7, no halt.
  - Response: done after 90 cycles, timeout = 1, cycle_count = 90, entry_count = 0.
- Wrap and overflow:
  - Stimulus: DEPTH = 16; pc_in increments every cycle for 20 changes, then halt.
  - Response: entry_count = 16, overflow = 1, rd_addr 0 -> pc 5, rd_addr 15 -> pc 20.
- Restart:
  - Stimulus: after DONE, pulse start.
  - Response: overflow, timeout, done = 0, cycle_count restarts from 0; start pulsed during RUN has no effect.
- Macro undefined:
  - Stimulus: same as the halt-stop scenario.
  - Response: rd_data upper NREG*W bits = 0; PCs 1,2,3 as before.

Source files
------------

// File: rtl/nrisc_run_monitor_if.sv
// Bus bundle for nrisc_run_monitor: run control, core observation inputs,
// trace read port and run status. The bench/host drives the master side.
interface nrisc_run_monitor_if #(
    parameter int W    = 8,
    parameter int NREG = 4,
    parameter int AW   = 4,
    parameter int CW   = 16
);
    logic              start;
    logic              halt_in;
    logic [W-1:0]      pc_in;
    logic [NREG*W-1:0] regs_in;
    logic [AW-1:0]     rd_addr;
    logic [W+NREG*W-1:0] rd_data;
    logic              running;
    logic              done;
    logic              timeout;
    logic [CW-1:0]     cycle_count;
    logic [AW:0]       entry_count;
    logic              overflow;

    modport master (
        output start, halt_in, pc_in, regs_in, rd_addr,
        input  rd_data, running, done, timeout, cycle_count, entry_count, overflow
    );

    modport slave (
        input  start, halt_in, pc_in, regs_in, rd_addr,
        output rd_data, running, done, timeout, cycle_count, entry_count, overflow
    );
endinterface

// File: rtl/nrisc_run_monitor.sv
// Run controller and PC trace monitor for the 8-bit nRisc core.
// A run starts on 'start', ends on halt_in or after MAX_CYCLES cycles, and logs
// every PC change into a circular buffer readable after the run (oldest first).
// Optional build macro NRISC_TRACE_REGS_EN: each entry also stores regs_in.
module nrisc_run_monitor #(
    parameter int W          = 8,
    parameter int NREG       = 4,
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int MAX_CYCLES = 90,
    parameter int CW         = 16
) (
    input  logic                clk,
    input  logic                rst,
    nrisc_run_monitor_if.slave  bus
);
    localparam int RW = NREG * W;
    localparam int OW = W + RW;
`ifdef NRISC_TRACE_REGS_EN
    localparam int EW = OW;
`else
    localparam int EW = W;
`endif
    localparam logic [AW:0]   FULL     = DEPTH[AW:0];
    localparam logic [CW-1:0] LAST_CYC = CW'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   entry;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     entry_count;
    logic [CW-1:0]   cycle_count;
    logic [W-1:0]    last_pc;
    logic            timeout;
    logic            overflow;
    logic [OW-1:0]   rd_data;
    logic            pc_change;
    logic            last_cycle;
    logic [AW-1:0]   rd_phys;

    // Entry count saturates once the buffer is full; older entries get overwritten.
    function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
        if (v == FULL)
            return v;
        return v + {{AW{1'b0}}, 1'b1};
    endfunction

`ifdef NRISC_TRACE_REGS_EN
    assign entry = {bus.regs_in, bus.pc_in};
`else
    assign entry = bus.pc_in;
    logic unused_regs;
    assign unused_regs = ^bus.regs_in;
`endif

    assign pc_change  = (bus.pc_in != last_pc);
    assign last_cycle = (cycle_count == LAST_CYC);
    // Oldest retained entry sits entry_count slots behind the write pointer.
    assign rd_phys    = wr_ptr - entry_count[AW-1:0] + bus.rd_addr;

    // State register; reset aborts any run.
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next state: halt and the cycle limit both end a run; start is ignored in RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_RUN;
            S_RUN:   if (bus.halt_in || last_cycle) state_nxt = S_DONE;
            S_DONE:  if (bus.start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from state plus the registered counters/flags.
    always_comb begin
        bus.running     = (state == S_RUN);
        bus.done        = (state == S_DONE);
        bus.timeout     = timeout;
        bus.overflow    = overflow;
        bus.cycle_count = cycle_count;
        bus.entry_count = entry_count;
        bus.rd_data     = rd_data;
    end

    // Run bookkeeping: counters, write pointer, last seen PC and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= '0;
            entry_count <= '0;
            wr_ptr      <= '0;
            last_pc     <= '0;
            timeout     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        cycle_count <= '0;
                        entry_count <= '0;
                        wr_ptr      <= '0;
                        timeout     <= 1'b0;
                        overflow    <= 1'b0;
                        // Seed with the current PC so the first RUN cycle does not log.
                        last_pc     <= bus.pc_in;
                    end
                end
                S_RUN: begin
                    cycle_count <= cycle_count + CW'(1);
                    if (pc_change) begin
                        wr_ptr      <= wr_ptr + AW'(1);
                        last_pc     <= bus.pc_in;
                        entry_count <= sat_inc(entry_count);
                        if (entry_count == FULL)
                            overflow <= 1'b1;
                    end
                    // Halt has priority: a run ending on halt never reports timeout.
                    if (!bus.halt_in && last_cycle)
                        timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Trace buffer write on every PC change during RUN.
    always_ff @(posedge clk) begin
        if (!rst && state == S_RUN && pc_change)
            mem[wr_ptr] <= entry;
    end

    // Registered read port, oldest-first indexing; out-of-range reads return zero.
    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else if ({1'b0, bus.rd_addr} < entry_count)
            rd_data <= OW'(mem[rd_phys]);
        else
            rd_data <= '0;
    end
endmodule

// File: tb/tb_nrisc_run_monitor.sv
// Directed testbench for nrisc_run_monitor (default parameters), works with or
// without NRISC_TRACE_REGS_EN defined.
module tb_nrisc_run_monitor;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    int   run_edges;

    nrisc_run_monitor_if #(.W(8), .NREG(4), .AW(4), .CW(16)) bus ();

    nrisc_run_monitor #(
        .W(8), .NREG(4), .DEPTH(16), .AW(4), .MAX_CYCLES(90), .CW(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] regs_for(input logic [7:0] p);
        return {p + 8'h40, p + 8'h30, p + 8'h20, p + 8'h10};
    endfunction

    function automatic logic [39:0] exp_entry(input logic [7:0] p);
`ifdef NRISC_TRACE_REGS_EN
        return {regs_for(p), p};
`else
        return {32'h0, p};
`endif
    endfunction

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.halt_in = 1'b0;
        bus.pc_in = 8'h00;
        bus.regs_in = 32'h0;
        bus.rd_addr = 4'd0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_running",  40'(bus.running), 40'd0);
        check("rst_done",     40'(bus.done), 40'd0);
        check("rst_timeout",  40'(bus.timeout), 40'd0);
        check("rst_overflow", 40'(bus.overflow), 40'd0);
        check("rst_cycles",   40'(bus.cycle_count), 40'd0);
        check("rst_entries",  40'(bus.entry_count), 40'd0);
        check("rst_rd_data",  bus.rd_data, 40'd0);

        // Reset mid-run
        bus.pc_in = 8'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.pc_in = 8'd1; tick();
        bus.pc_in = 8'd2; tick();
        check("mid_running",  40'(bus.running), 40'd1);
        check("mid_entries",  40'(bus.entry_count), 40'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_running", 40'(bus.running), 40'd0);
        check("mid_rst_done",    40'(bus.done), 40'd0);
        check("mid_rst_entries", 40'(bus.entry_count), 40'd0);
        check("mid_rst_cycles",  40'(bus.cycle_count), 40'd0);

        // Halt stop: PCs 1,2,3 logged, halt on a cycle with unchanged PC
        bus.pc_in = 8'd0; bus.regs_in = regs_for(8'd0); bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int p = 1; p <= 3; p++) begin
            bus.pc_in = 8'(p);
            bus.regs_in = regs_for(8'(p));
            tick();
        end
        bus.halt_in = 1'b1;
        tick();
        bus.halt_in = 1'b0;
        check("halt_done",    40'(bus.done), 40'd1);
        check("halt_running", 40'(bus.running), 40'd0);
        check("halt_timeout", 40'(bus.timeout), 40'd0);
        check("halt_entries", 40'(bus.entry_count), 40'd3);
        check("halt_cycles",  40'(bus.cycle_count), 40'd4);
        // PC changes in DONE must not log
        bus.pc_in = 8'd9; bus.regs_in = 32'hDEADBEEF;
        for (int a = 0; a < 3; a++) begin
            bus.rd_addr = 4'(a);
            tick();
            check($sformatf("halt_rd%0d", a), bus.rd_data, exp_entry(8'(a + 1)));
        end
        bus.rd_addr = 4'd3;
        tick();
        check("halt_rd_oob",  bus.rd_data, 40'd0);
        check("halt_entries_hold", 40'(bus.entry_count), 40'd3);

        // Wrap and overflow: 20 changes, halt on the cycle of the 20th
        bus.pc_in = 8'd0; bus.regs_in = regs_for(8'd0); bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int p = 1; p <= 20; p++) begin
            bus.pc_in = 8'(p);
            bus.regs_in = regs_for(8'(p));
            bus.halt_in = (p == 20);
            tick();
        end
        bus.halt_in = 1'b0;
        check("wrap_done",     40'(bus.done), 40'd1);
        check("wrap_timeout",  40'(bus.timeout), 40'd0);
        check("wrap_entries",  40'(bus.entry_count), 40'd16);
        check("wrap_overflow", 40'(bus.overflow), 40'd1);
        check("wrap_cycles",   40'(bus.cycle_count), 40'd20);
        bus.rd_addr = 4'd0;  tick();
        check("wrap_rd0",  bus.rd_data, exp_entry(8'd5));
        bus.rd_addr = 4'd1;  tick();
        check("wrap_rd1",  bus.rd_data, exp_entry(8'd6));
        bus.rd_addr = 4'd15; tick();
        check("wrap_rd15", bus.rd_data, exp_entry(8'd20));

        // Restart from DONE, start during RUN ignored, then timeout with constant PC
        bus.pc_in = 8'd7; bus.start = 1'b1;
        tick();
        check("rs_running",  40'(bus.running), 40'd1);
        check("rs_done",     40'(bus.done), 40'd0);
        check("rs_overflow", 40'(bus.overflow), 40'd0);
        check("rs_timeout",  40'(bus.timeout), 40'd0);
        check("rs_cycles",   40'(bus.cycle_count), 40'd0);
        check("rs_entries",  40'(bus.entry_count), 40'd0);
        tick();
        bus.start = 1'b0;
        run_edges = 1;
        check("rs_start_ignored", 40'(bus.cycle_count), 40'd1);
        while (!bus.done && run_edges < 200) begin
            tick();
            run_edges++;
        end
        check("to_done",      40'(bus.done), 40'd1);
        check("to_run_edges", 40'(run_edges), 40'd90);
        check("to_timeout",   40'(bus.timeout), 40'd1);
        check("to_cycles",    40'(bus.cycle_count), 40'd90);
        check("to_entries",   40'(bus.entry_count), 40'd0);
        check("to_overflow",  40'(bus.overflow), 40'd0);
        tick();
        tick();
        check("to_hold_done",   40'(bus.done), 40'd1);
        check("to_hold_cycles", 40'(bus.cycle_count), 40'd90);

        // Halt on the first RUN cycle
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.halt_in = 1'b1;
        tick();
        bus.halt_in = 1'b0;
        check("h1_done",    40'(bus.done), 40'd1);
        check("h1_cycles",  40'(bus.cycle_count), 40'd1);
        check("h1_timeout", 40'(bus.timeout), 40'd0);

        // Start and reset together: reset wins
        rst = 1'b1; bus.start = 1'b1;
        tick();
        rst = 1'b0; bus.start = 1'b0;
        check("sr_running", 40'(bus.running), 40'd0);
        check("sr_done",    40'(bus.done), 40'd0);
        check("sr_cycles",  40'(bus.cycle_count), 40'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
